seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 175 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexed driver for a common-anode multi-digit hex 7-segment display.
// Each digit is driven for DIV clock cycles in turn. The digit values, decimal
// points, digit mask and leading-zero mode are captured once per frame, so a
// frame never shows a mix of old and new values.
//
// Ports
//   clk        sole clock, rising edge
//   rstn       asynchronous active-low reset
//   en         scan enable; 0 blanks the display and parks the scanner
//   in         DIGITS hex nibbles, digit 0 in in[3:0]
//   dp_in      per-digit decimal point request, 1 = lit
//   digit_en   per-digit enable mask, 0 = digit always dark
//   lz_en      leading-zero suppression enable
//   an         digit anodes, active-low, at most one low
//   seg        segments {g,f,e,d,c,b,a}, active-low
//   dp         decimal point, active-low
//   idx        index of the digit currently driven
//   frame_done one-cycle pulse when a full scan of all digits completes
module seg_scan_ctrl #(
  parameter int DIGITS = 8,
  parameter int DIV    = 100000,
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  lz_en,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [IW-1:0]         idx,
  output logic                  frame_done
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t               state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [IW-1:0]        idx_d;
  logic [4*DIGITS-1:0]  snap_in, snap_in_d;
  logic [DIGITS-1:0]    snap_dp, snap_dp_d;
  logic [DIGITS-1:0]    snap_en, snap_en_d;
  logic                 snap_lz, snap_lz_d;
  logic [DIGITS-1:0]    an_d;
  logic [6:0]           seg_d;
  logic                 dp_d;
  logic                 frame_done_d;
  logic [3:0]           digit_val;
  logic                 lz_blank;
  logic                 blank;

  function automatic logic [6:0] decode(input logic [3:0] h);
    case (h)
      4'h0: decode = 7'h40;
      4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;
      4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;
      4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;
      4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;
      4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;
      4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;
      4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;
      default: decode = 7'h0E;
    endcase
  endfunction

  // Next-state logic. The display outputs are computed from the *next*
  // snapshot and index so that the registered an/seg/dp change on the same
  // edge as idx, including the very first digit of a fresh snapshot.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    idx_d        = idx;
    snap_in_d    = snap_in;
    snap_dp_d    = snap_dp;
    snap_en_d    = snap_en;
    snap_lz_d    = snap_lz;
    frame_done_d = 1'b0;

    unique case (state)
      IDLE: begin
        if (en) begin
          state_d   = SCAN;
          cnt_d     = '0;
          idx_d     = '0;
          snap_in_d = in;
          snap_dp_d = dp_in;
          snap_en_d = digit_en;
          snap_lz_d = lz_en;
        end
      end
      SCAN: begin
        // Dropping en wins over a frame-completing tick: no pulse, no reload.
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt == CW'(DIV - 1)) begin
          cnt_d = '0;
          if (idx == IW'(DIGITS - 1)) begin
            idx_d        = '0;
            snap_in_d    = in;
            snap_dp_d    = dp_in;
            snap_en_d    = digit_en;
            snap_lz_d    = lz_en;
            frame_done_d = 1'b1;
          end else begin
            idx_d = idx + 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
    endcase

    // A digit above 0 is a leading zero when it and every higher digit are 0.
    digit_val = snap_in_d[4*idx_d +: 4];
    lz_blank  = snap_lz_d && (idx_d != '0);
    for (int k = 0; k < DIGITS; k++) begin
      if ((k >= int'(idx_d)) && (snap_in_d[4*k +: 4] != 4'h0)) begin
        lz_blank = 1'b0;
      end
    end
    blank = !snap_en_d[idx_d] || lz_blank;

    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if ((state_d == SCAN) && !blank) begin
      an_d[idx_d] = 1'b0;
      seg_d       = decode(digit_val);
      dp_d        = ~snap_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      snap_in    <= '0;
      snap_dp    <= '0;
      snap_en    <= '0;
      snap_lz    <= 1'b0;
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      idx        <= idx_d;
      snap_in    <= snap_in_d;
      snap_dp    <= snap_dp_d;
      snap_en    <= snap_en_d;
      snap_lz    <= snap_lz_d;
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
// Self-checking bench for seg_scan_ctrl with DIGITS=8, DIV=4. The reference
// model tracks the scan as "active or not" plus a position within the frame
// (0..DIGITS*DIV-1) and derives the expected digit, blanking and segments
// arithmetically from the captured frame values.
module tb_seg_scan_ctrl;

  localparam int DIGITS = 8;
  localparam int DIV    = 4;
  localparam int FRAME  = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [31:0] in_val;
  logic [7:0]  dp_in;
  logic [7:0]  digit_en;
  logic        lz_en;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [2:0]  idx;
  logic        frame_done;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  bit          m_active;
  int          m_pos;
  logic [31:0] m_in;
  logic [7:0]  m_dp;
  logic [7:0]  m_den;
  logic        m_lz;
  logic        m_fd;

  logic [6:0] seg_table [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .in         (in_val),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .lz_en      (lz_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .idx        (idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic e, input logic [31:0] v, input logic [7:0] d,
                               input logic [7:0] m, input logic l);
    en       = e;
    in_val   = v;
    dp_in    = d;
    digit_en = m;
    lz_en    = l;
  endtask

  task automatic modelReset();
    m_active = 1'b0;
    m_pos    = 0;
    m_in     = '0;
    m_dp     = '0;
    m_den    = '0;
    m_lz     = 1'b0;
    m_fd     = 1'b0;
  endtask

  task automatic modelCapture();
    m_in  = in_val;
    m_dp  = dp_in;
    m_den = digit_en;
    m_lz  = lz_en;
  endtask

  // One rising edge worth of model behaviour, using the inputs present at it.
  task automatic modelEdge();
    m_fd = 1'b0;
    if (!m_active) begin
      if (en) begin
        m_active = 1'b1;
        m_pos    = 0;
        modelCapture();
      end
    end else if (!en) begin
      m_active = 1'b0;
      m_pos    = 0;
    end else begin
      m_pos = m_pos + 1;
      if (m_pos == FRAME) begin
        m_pos = 0;
        modelCapture();
        m_fd = 1'b1;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    int          e_idx;
    logic [31:0] upper;
    bit          dark;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    e_idx = m_active ? (m_pos / DIV) : 0;
    upper = m_in >> (4 * e_idx);
    dark  = !m_den[e_idx] || (m_lz && (e_idx > 0) && (upper == 32'h0));
    e_an  = 8'hFF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    if (m_active && !dark) begin
      e_an  = ~(8'h01 << e_idx);
      e_seg = seg_table[upper[3:0]];
      e_dp  = ~m_dp[e_idx];
    end
    vectors++;
    assert (an === e_an) else begin
      miscompares++;
      $error("[TB] FAIL %s an: got %h expected %h", tag, an, e_an);
    end
    vectors++;
    assert (seg === e_seg) else begin
      miscompares++;
      $error("[TB] FAIL %s seg: got %h expected %h", tag, seg, e_seg);
    end
    vectors++;
    assert (dp === e_dp) else begin
      miscompares++;
      $error("[TB] FAIL %s dp: got %b expected %b", tag, dp, e_dp);
    end
    vectors++;
    assert (idx === 3'(e_idx)) else begin
      miscompares++;
      $error("[TB] FAIL %s idx: got %0d expected %0d", tag, idx, e_idx);
    end
    vectors++;
    assert (frame_done === m_fd) else begin
      miscompares++;
      $error("[TB] FAIL %s frame_done: got %b expected %b", tag, frame_done, m_fd);
    end
  endtask

  task automatic runCycles(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput(tag);
    end
  endtask

  initial begin
    rstn = 1'b1;
    applyStimulus(1'b1, 32'h76543210, 8'h00, 8'hFF, 1'b0);
    modelReset();
    #1 rstn = 1'b0;
    #1 checkOutput("reset");

    $display("[TB] basic scan 76543210");
    @(negedge clk) rstn = 1'b1;
    runCycles(34, "basic");

    $display("[TB] mid-frame input change");
    runCycles(8, "pre_change");
    applyStimulus(1'b1, 32'hFFFFFFFF, 8'h00, 8'hFF, 1'b0);
    runCycles(60, "no_tearing");

    $display("[TB] leading-zero suppression");
    applyStimulus(1'b1, 32'h00000305, 8'h00, 8'hFF, 1'b1);
    runCycles(70, "lz_305");
    applyStimulus(1'b1, 32'h00000000, 8'h00, 8'hFF, 1'b1);
    runCycles(70, "lz_zero");

    $display("[TB] digit mask and decimal point");
    applyStimulus(1'b1, $urandom, 8'h02, 8'h0F, 1'b0);
    runCycles(70, "mask_dp");

    $display("[TB] enable drop and restart");
    applyStimulus(1'b1, $urandom, $urandom, 8'hFF, 1'b0);
    runCycles(40, "sync");
    applyStimulus(1'b0, 32'h0, 8'h00, 8'hFF, 1'b0);
    runCycles(3, "en_off");
    applyStimulus(1'b1, $urandom, $urandom, 8'hFF, 1'b0);
    runCycles(10, "restart");
    applyStimulus(1'b0, $urandom, $urandom, 8'hFF, 1'b0);
    runCycles(2, "en_drop");
    applyStimulus(1'b1, $urandom, $urandom, 8'hFF, 1'b0);
    runCycles(40, "restart2");

    $display("[TB] enable drop on frame-completing tick");
    applyStimulus(1'b0, 32'h0, 8'h00, 8'hFF, 1'b0);
    runCycles(1, "idle");
    applyStimulus(1'b1, $urandom, $urandom, 8'hFF, 1'b0);
    runCycles(FRAME, "to_tick");
    applyStimulus(1'b0, $urandom, $urandom, 8'hFF, 1'b0);
    runCycles(2, "tick_drop");

    $display("[TB] randomized stimulus");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 59) != 0),
                    $urandom >> ($urandom_range(0, 8) * 4),
                    8'($urandom), 8'($urandom | ($urandom_range(0, 1) ? 32'hFF : 32'h0)),
                    1'($urandom_range(0, 1)));
      runCycles(1, "random");
    end

    $display("[TB] asynchronous reset mid-scan");
    applyStimulus(1'b1, $urandom, $urandom, 8'hFF, 1'b0);
    runCycles(13, "pre_rst");
    @(posedge clk);
    modelEdge();
    #1 checkOutput("pre_rst_edge");
    #2 rstn = 1'b0;
    #1;
    modelReset();
    checkOutput("async_rst");
    @(negedge clk) rstn = 1'b1;
    #1 checkOutput("rst_release");
    runCycles(40, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
